// File: rtl/datapath_pkg.sv
// Shared datapath types for the word-select helpers.
package datapath_pkg;

  localparam int WORD_W = 64;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {SEL0, SEL1, SEL2, SEL3} mux4_sel_t;

endpackage

// File: rtl/mux4_1_bit.sv
// One-bit 4:1 mux built from two levels of 2:1 selection (sel[0], then sel[1]).
module mux4_1_bit
  import datapath_pkg::*;
(
  input  logic [1:0] sel_i,
  input  logic [3:0] leg_i,
  output logic       y_o
);

  logic lo_s;
  logic hi_s;

  assign lo_s = sel_i[0] ? leg_i[1] : leg_i[0];
  assign hi_s = sel_i[0] ? leg_i[3] : leg_i[2];
  assign y_o  = sel_i[1] ? hi_s : lo_s;

endmodule

// File: rtl/mux_4to1_64bit.sv
// 4:1 word multiplexer with a combinational output and a registered copy.
module mux_4to1_64bit
  import datapath_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         sel,
  input  logic [4*WIDTH-1:0] in,
  output logic [WIDTH-1:0]   out,
  output logic [WIDTH-1:0]   out_q
);

  logic [WIDTH-1:0] out_d;

  // Bit i of every leg feeds only output bit i; no cross-bit logic.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    mux4_1_bit u_bit (
      .sel_i (sel),
      .leg_i ({in[3*WIDTH+i], in[2*WIDTH+i], in[WIDTH+i], in[i]}),
      .y_o   (out[i])
    );
  end

  assign out_d = out;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q <= {WIDTH{1'b0}};
    end else begin
      out_q <= out_d;
    end
  end

endmodule

// File: tb/tb_mux_4to1_64bit.sv
// Directed bench for mux_4to1_64bit: leg isolation, lane insertion, walking one, reset, random.
module tb_mux_4to1_64bit;

  logic         clk;
  logic         reset;
  logic [1:0]   sel;
  logic [255:0] in;
  logic [63:0]  out;
  logic [63:0]  out_q;

  logic [63:0]  leg [4];
  logic [63:0]  exp_prev;
  int           n_checks;
  int           n_errors;

  mux_4to1_64bit dut (
    .clk   (clk),
    .reset (reset),
    .sel   (sel),
    .in    (in),
    .out   (out),
    .out_q (out_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic load_legs(input logic [63:0] l0, input logic [63:0] l1,
                           input logic [63:0] l2, input logic [63:0] l3);
    leg[0] = l0;
    leg[1] = l1;
    leg[2] = l2;
    leg[3] = l3;
    in = {l3, l2, l1, l0};
  endtask

  initial begin
    logic [63:0] exp_leg [4];
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    sel   = 2'b00;
    in    = 256'd0;
    for (int i = 0; i < 4; i++) leg[i] = 64'd0;

    #1;
    check("reset_out_q", out_q, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Leg isolation
    load_legs(64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB,
              64'hCCCC_CCCC_CCCC_CCCC, 64'hDDDD_DDDD_DDDD_DDDD);
    exp_leg[0] = 64'hAAAA_AAAA_AAAA_AAAA;
    exp_leg[1] = 64'hBBBB_BBBB_BBBB_BBBB;
    exp_leg[2] = 64'hCCCC_CCCC_CCCC_CCCC;
    exp_leg[3] = 64'hDDDD_DDDD_DDDD_DDDD;
    #2;
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      #10;
      check($sformatf("iso_sel%0d", s), out, exp_leg[s]);
    end

    // Lane insertion into a zero replacee
    load_legs(64'h0000_0000_0000_FFFF, 64'h0000_0000_FFFF_0000,
              64'h0000_FFFF_0000_0000, 64'hFFFF_0000_0000_0000);
    exp_leg[0] = 64'h0000_0000_0000_FFFF;
    exp_leg[1] = 64'h0000_0000_FFFF_0000;
    exp_leg[2] = 64'h0000_FFFF_0000_0000;
    exp_leg[3] = 64'hFFFF_0000_0000_0000;
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      #10;
      check($sformatf("lane0_sel%0d", s), out, exp_leg[s]);
    end

    // Lane insertion into an AAAA replacee
    load_legs(64'hAAAA_AAAA_AAAA_FFFF, 64'hAAAA_AAAA_FFFF_AAAA,
              64'hAAAA_FFFF_AAAA_AAAA, 64'hFFFF_AAAA_AAAA_AAAA);
    sel = 2'd2;
    #10;
    check("laneA_sel2", out, 64'hAAAA_FFFF_AAAA_AAAA);
    sel = 2'd3;
    #10;
    check("laneA_sel3", out, 64'hFFFF_AAAA_AAAA_AAAA);

    // Walking one on leg 1
    for (int k = 0; k < 64; k++) begin
      load_legs(64'd0, 64'd1 << k, 64'd0, 64'd0);
      sel = 2'd1;
      #1;
      check($sformatf("walk_k%0d", k), out, 64'd1 << k);
      sel = 2'd0;
      #1;
      check($sformatf("walk0_k%0d", k), out, 64'd0);
    end

    // Register capture then asynchronous reset mid-cycle
    load_legs(64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888,
              64'h9999_AAAA_BBBB_CCCC, 64'hDDDD_EEEE_FFFF_0123);
    sel = 2'd3;
    @(posedge clk);
    #1;
    check("capture_sel3", out_q, 64'hDDDD_EEEE_FFFF_0123);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_q", out_q, 64'd0);
    sel = 2'd1;
    #1;
    check("reset_out_tracks", out, 64'h5555_6666_7777_8888);
    @(posedge clk);
    #1;
    check("reset_hold_q", out_q, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    sel = 2'd2;
    #1;
    check("post_release_q", out_q, 64'd0);
    @(posedge clk);
    #1;
    check("first_capture", out_q, 64'h9999_AAAA_BBBB_CCCC);

    // Random vectors: out combinational, out_q one cycle behind
    exp_prev = 64'h9999_AAAA_BBBB_CCCC;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      load_legs({$urandom, $urandom}, {$urandom, $urandom},
                {$urandom, $urandom}, {$urandom, $urandom});
      sel = 2'($urandom_range(3, 0));
      #1;
      check("rand_q_hold", out_q, exp_prev);
      check("rand_out", out, leg[sel]);
      exp_prev = leg[sel];
      @(posedge clk);
      #1;
      check("rand_q", out_q, exp_prev);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
